serial_add_ctrl: RTL and testbench

Multi-cycle wide adder/subtractor controller that sequences a single 4-bit ripple-carry adder slice. It processes WIDTH-bit operands one nibble per cycle, LSB nibble first. A registered carry links successive nibbles, and a start/busy/done handshake frames each operation. It sits between a requester (testbench, ALU front end or datapath FSM) and the shared 4-bit adder hardware, trading latency for area.

---
 rtl/serial_add_ctrl_pkg.sv | 18 +
 rtl/serial_add_ctrl_if.sv | 27 ++
 rtl/serial_add_ctrl_adder4.sv | 27 ++
 rtl/serial_add_ctrl.sv | 121 ++++++++++++
 tb/tb_serial_add_ctrl.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the serial add/subtract controller.
//   state_t : FSM state encoding (IDLE/RUN/DONE)
//   OP_*    : operation codes carried on the op input
//   SLICE_W : width of the shared adder slice
package serial_add_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam int unsigned SLICE_W = 4;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Request/response bundle between a requester and serial_add_ctrl.
//   master : requester side (drives start/op/a/b, observes status and result)
//   slave  : controller side
interface serial_add_ctrl_if #(
  parameter int unsigned WIDTH = 16
);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output start, op, a, b,
    input  busy, done, result, cout, ovf, zero
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, cout, ovf, zero
  );
endinterface

// File: rtl/serial_add_ctrl_adder4.sv
// 4-bit ripple-carry adder slice; the single shared arithmetic resource.
//   a, b : nibble operands   cin  : carry in
//   s    : nibble sum        cout : carry out of bit 3
module adder4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [4:0] c;

  // Explicit bit-level carry chain.
  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int i = 0; i < 4; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout = c[4];

endmodule

// File: rtl/serial_add_ctrl.sv
// Multi-cycle WIDTH-bit add/subtract controller sequencing one 4-bit slice,
// LSB nibble first, with a start/busy/done handshake.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of serial_add_ctrl_if (start/op/a/b in;
//              busy/done/result/cout/ovf/zero out, all registered)
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  serial_add_ctrl_if.slave bus
);

  localparam int unsigned NIB   = WIDTH / SLICE_W;
  localparam int unsigned CNT_W = $clog2(NIB);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NIB - 1);

  state_t           state, state_nx;
  logic             accept_c;
  logic [WIDTH-1:0] sa, sb, acc;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       sum_c;
  logic             slice_cout_c;
  logic [WIDTH-1:0] final_c;

  logic             busy_q, done_q, cout_q, ovf_q, zero_q;
  logic [WIDTH-1:0] result_q;

  adder4 u_adder4 (
    .a    (sa[3:0]),
    .b    (sb[3:0]),
    .cin  (carry),
    .s    (sum_c),
    .cout (slice_cout_c)
  );

  // Accumulator contents once the current nibble lands at the top.
  assign final_c = {sum_c, acc[WIDTH-1:SLICE_W]};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Next-state and start acceptance; start is ignored while in RUN.
  always_comb begin
    state_nx = state;
    accept_c = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          accept_c = 1'b1;
          state_nx = ST_RUN;
        end
      end
      ST_RUN: begin
        if (cnt == LAST) state_nx = ST_DONE;
      end
      ST_DONE: begin
        if (bus.start) begin
          accept_c = 1'b1;
          state_nx = ST_RUN;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Operand shifters, carry, step counter, accumulator and result registers.
  // On the last step sa[3]/sb[3] hold the MSBs of A and effective B.
  always_ff @(posedge clk) begin
    if (rst) begin
      sa       <= '0;
      sb       <= '0;
      acc      <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      busy_q <= (state_nx == ST_RUN);
      done_q <= (state_nx == ST_DONE);
      if (accept_c) begin
        sa    <= bus.a;
        sb    <= (bus.op == OP_ADD) ? bus.b : ~bus.b;
        carry <= bus.op;
        cnt   <= '0;
      end else if (state == ST_RUN) begin
        sa    <= {SLICE_W'(0), sa[WIDTH-1:SLICE_W]};
        sb    <= {SLICE_W'(0), sb[WIDTH-1:SLICE_W]};
        carry <= slice_cout_c;
        cnt   <= cnt + CNT_W'(1);
        acc   <= final_c;
        if (cnt == LAST) begin
          result_q <= final_c;
          cout_q   <= slice_cout_c;
          ovf_q    <= (sa[3] == sb[3]) && (sum_c[3] != sa[3]);
          zero_q   <= (final_c == '0);
        end
      end
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.cout   = cout_q;
  assign bus.ovf    = ovf_q;
  assign bus.zero   = zero_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl at WIDTH=16: directed cases with
// literal expectations plus randomized traffic compared every cycle against
// an arithmetic reference model.
module tb_serial_add_ctrl;

  localparam int unsigned W   = 16;
  localparam int unsigned NIB = W / 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_add_ctrl_if #(.WIDTH(W)) bus();

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Reference model state: cycles of RUN remaining, and the expected outputs.
  int           m_left = 0;
  logic         m_done = 1'b0;
  logic [W-1:0] m_res  = '0;
  logic         m_cout = 1'b0;
  logic         m_ovf  = 1'b0;
  logic         m_zero = 1'b0;
  logic [W-1:0] p_a, p_b;
  logic         p_op;

  task automatic model_complete();
    longint ua, ub, sa_v, sb_v, sr;
    ua   = longint'(p_a);
    ub   = longint'(p_b);
    sa_v = longint'($signed(p_a));
    sb_v = longint'($signed(p_b));
    if (p_op) begin
      m_res  = W'(ua - ub);
      m_cout = (ua >= ub);
      sr     = sa_v - sb_v;
    end else begin
      m_res  = W'(ua + ub);
      m_cout = ((ua + ub) >= (longint'(1) << W));
      sr     = sa_v + sb_v;
    end
    m_ovf  = (sr > ((longint'(1) << (W - 1)) - 1)) || (sr < -(longint'(1) << (W - 1)));
    m_zero = (m_res == '0);
  endtask

  task automatic model_step();
    if (rst) begin
      m_left = 0;
      m_done = 1'b0;
      m_res  = '0;
      m_cout = 1'b0;
      m_ovf  = 1'b0;
      m_zero = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_done = 1'b1;
          model_complete();
        end
      end else if (bus.start) begin
        m_left = NIB;
        p_a    = bus.a;
        p_b    = bus.b;
        p_op   = bus.op;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Every-cycle comparison of all outputs against the model.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      n_tests++;
      if (bus.busy !== (m_left > 0) || bus.done !== m_done || bus.result !== m_res ||
          bus.cout !== m_cout || bus.ovf !== m_ovf || bus.zero !== m_zero) begin
        n_fail++;
        $display("FAIL cycle_compare t=%0t busy=%b/%b done=%b/%b result=%h/%h cout=%b/%b ovf=%b/%b zero=%b/%b (got/expected)",
                 $time, bus.busy, (m_left > 0), bus.done, m_done, bus.result, m_res,
                 bus.cout, m_cout, bus.ovf, m_ovf, bus.zero, m_zero);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Called at a negedge; start is seen by the next rising edge.
  task automatic op_go(input logic [W-1:0] a, input logic [W-1:0] b, input logic op);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.op    = op;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string name, output int nb);
    nb = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.done === 1'b1) return;
      if (bus.busy === 1'b1) nb++;
      @(negedge clk);
    end
    n_tests++;
    n_fail++;
    $display("FAIL %s_timeout: got no done expected done within 20 cycles", name);
  endtask

  task automatic check_result(input string name, input logic [W-1:0] r,
                              input logic c, input logic v, input logic z);
    check({name, "_result"}, 32'(bus.result), 32'(r));
    check({name, "_model"},  32'(m_res),      32'(r));
    check({name, "_cout"},   32'(bus.cout),   32'(c));
    check({name, "_ovf"},    32'(bus.ovf),    32'(v));
    check({name, "_zero"},   32'(bus.zero),   32'(z));
  endtask

  task automatic directed(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic op, input logic [W-1:0] r,
                          input logic c, input logic v, input logic z);
    int nb;
    op_go(a, b, op);
    wait_done(name, nb);
    check({name, "_busy_cycles"}, 32'(nb), 32'(NIB));
    check_result(name, r, c, v, z);
    @(negedge clk);
  endtask

  initial begin
    int nb;
    int dcnt;
    logic [W-1:0] ra, rb;

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.op    = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check_result("reset", 16'h0000, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    directed("add",      16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0);
    directed("sub_brw",  16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    directed("sub_eq",   16'hABCD, 16'hABCD, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
    directed("add_ovf",  16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    directed("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);

    // Start pulsed during RUN must be ignored.
    op_go(16'h1111, 16'h2222, 1'b0);
    @(negedge clk);
    op_go(16'hFFFF, 16'h0F0F, 1'b1);
    wait_done("run_ignore", nb);
    check_result("run_ignore", 16'h3333, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);

    // Back-to-back start in the DONE cycle.
    op_go(16'h0100, 16'h0001, 1'b0);
    wait_done("b2b_first", nb);
    check_result("b2b_first", 16'h0101, 1'b0, 1'b0, 1'b0);
    op_go(16'h0010, 16'h0001, 1'b1);
    check("b2b_busy", 32'(bus.busy), 32'd1);
    check("b2b_hold", 32'(bus.result), 32'h0101);
    wait_done("b2b_second", nb);
    check("b2b_busy_cycles", 32'(nb), 32'(NIB));
    check_result("b2b_second", 16'h000F, 1'b1, 1'b0, 1'b0);
    @(negedge clk);

    // Reset on the second RUN cycle aborts without a done pulse.
    op_go(16'h4321, 16'h1234, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_result", 32'(bus.result), 32'h0000);
    dcnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) dcnt++;
    end
    check("abort_no_done", 32'(dcnt), 32'd0);
    directed("after_abort", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0);

    // Random traffic, including starts during RUN and in DONE.
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 4))
        0:       ra = 16'hFFFF;
        1:       ra = 16'h8000;
        2:       ra = 16'h7FFF;
        default: ra = W'($urandom);
      endcase
      case ($urandom_range(0, 4))
        0:       rb = ra;
        1:       rb = 16'h0001;
        default: rb = W'($urandom);
      endcase
      bus.a     = ra;
      bus.b     = rb;
      bus.op    = 1'($urandom_range(0, 1));
      bus.start = ($urandom_range(0, 2) == 0);
      @(negedge clk);
    end
    bus.start = 1'b0;
    repeat (8) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
